// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the execute-stage ALU.
// Op codes live here so the decoder and the datapath cannot drift apart.
package alu_pkg;

    localparam int ALU_WIDTH   = 32;
    localparam int ALU_SHAMT_W = 5;

    localparam logic [3:0] ALU_ADD     = 4'b0000;
    localparam logic [3:0] ALU_SUB     = 4'b0001;
    localparam logic [3:0] ALU_OR      = 4'b0010;
    localparam logic [3:0] ALU_AND     = 4'b0011;
    localparam logic [3:0] ALU_LUI     = 4'b0100;
    localparam logic [3:0] ALU_NOR     = 4'b0101;
    localparam logic [3:0] ALU_SLL     = 4'b0110;
    localparam logic [3:0] ALU_SRL     = 4'b0111;
    localparam logic [3:0] ALU_BRANCH  = 4'b1000;
    localparam logic [3:0] ALU_JR      = 4'b1001;
    localparam logic [3:0] ALU_INVALID = 4'b1111;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } alu_state_e;

    // Shifts are the only ops that may run over several cycles.
    function automatic logic isShiftOp(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Bit-serial shifter: holds the operand being shifted, the remaining count
// and the direction latched at load time; moves one position per step.
module alu_shift_iter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               step_i,
    input  logic               dirLeft_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [SHAMT_W-1:0] amount_i,
    output logic [WIDTH-1:0]   next_o,
    output logic               last_o
);

    logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               left_q, left_d;

    // Value after one more position in the latched direction, zero filled.
    always_comb begin
        next_o = left_q ? (shiftReg_q << 1) : (shiftReg_q >> 1);
    end

    // The step that consumes the final count produces the finished result.
    assign last_o = (count_q == SHAMT_W'(1));

    // Load on accept, otherwise advance one position per step until exhausted.
    always_comb begin
        shiftReg_d = shiftReg_q;
        count_d    = count_q;
        left_d     = left_q;
        if (load_i) begin
            shiftReg_d = data_i;
            count_d    = amount_i;
            left_d     = dirLeft_i;
        end else if (step_i && (count_q != '0)) begin
            shiftReg_d = next_o;
            count_d    = count_q - SHAMT_W'(1);
        end
    end

    // Shift state registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shiftReg_q <= '0;
            count_q    <= '0;
            left_q     <= 1'b0;
        end else begin
            shiftReg_q <= shiftReg_d;
            count_q    <= count_d;
            left_q     <= left_d;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Execute-stage ALU with a start/busy/done handshake. Single-cycle ops
// finish on the accept edge; non-zero shifts run bit-serially one position
// per clock so the multicycle controller stalls on busy.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH   = ALU_WIDTH,
    parameter int SHAMT_W = ALU_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         ALUOperation,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   ALUResult,
    output logic               Zero
);

    alu_state_e       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] singleResult;
    logic             shLoad;
    logic             shStep;
    logic [WIDTH-1:0] shNext;
    logic             shLast;

    alu_shift_iter #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load_i    (shLoad),
        .step_i    (shStep),
        .dirLeft_i (ALUOperation == ALU_SLL),
        .data_i    (B),
        .amount_i  (shamt),
        .next_o    (shNext),
        .last_o    (shLast)
    );

    // Result of every op that completes on the accept edge; a shift by zero
    // is simply B, and undefined codes produce zero.
    always_comb begin
        singleResult = '0;
        case (ALUOperation)
            ALU_ADD:            singleResult = A + B;
            ALU_SUB:            singleResult = A - B;
            ALU_OR:             singleResult = A | B;
            ALU_AND:            singleResult = A & B;
            ALU_LUI:            singleResult = WIDTH'({B[15:0], 16'h0000});
            ALU_NOR:            singleResult = ~(A | B);
            ALU_SLL, ALU_SRL:   singleResult = B;
            ALU_BRANCH:         singleResult = A - B;
            ALU_JR:             singleResult = A;
            default:            singleResult = '0;
        endcase
    end

    // Handshake FSM: accept in IDLE, step the shifter in SHIFT, and update
    // the result, Zero and done together only when an op finishes.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        shLoad   = 1'b0;
        shStep   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (isShiftOp(ALUOperation) && (shamt != '0)) begin
                        shLoad  = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        result_d = singleResult;
                        zero_d   = (singleResult == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                shStep = 1'b1;
                if (shLast) begin
                    result_d = shNext;
                    zero_d   = (shNext == '0);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any shift with no done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
        end
    end

    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;
    assign ALUResult = result_q;
    assign Zero      = zero_q;

endmodule
